gppcu_cmd_issuer: RTL and testbench

//  Host-side driver for the GPPCU test-queue command port. Accepts (cmd, data) requests, frames each as setup/strobe/release
//  on oCMD[31], and captures read-back words into a response FIFO. Also provides a WAIT_DONE pseudo-op for program completion.

---
 rtl/gppcu_cmd_issuer.sv | 169 ++++++++++++++++
 tb/tb_gppcu_cmd_issuer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gppcu_cmd_issuer.sv
// Host-side command issuer for the GPPCU test queue: frames requests as setup/strobe/release on oCMD[31]
// and queues read-back words. Define GPPCU_CMD_TIMEOUT_EN to add a WAIT_DONE timeout counter.
//
// state      | meaning
// ST_IDLE    | ready for a request when the response FIFO has room
// ST_SETUP   | fields driven, strobe low, SETUP_CYC cycles
// ST_STROBE  | strobe high, HOLD_CYC cycles
// ST_RELEASE | strobe low for one cycle; read types capture iRDATA at its end
// ST_WAIT    | WAIT_DONE pseudo-op, polling iDONE
module gppcu_cmd_issuer #(
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 1,
   parameter int RFBW      = 4,
   parameter int TMO_BW    = 16
) (
   input  logic        opclk,
   input  logic        inRST,
   input  logic        iREQ_VALID,
   output logic        oREQ_READY,
   input  logic [30:0] iREQ_CMD,
   input  logic [31:0] iREQ_DATA,
   output logic [31:0] oCMD,
   output logic [31:0] oDATA,
   input  logic [31:0] iRDATA,
   input  logic        iDONE,
   output logic        oRSP_VALID,
   input  logic        iRSP_READY,
   output logic [31:0] oRSP_DATA,
   output logic        oBUSY,
   output logic        oTIMEOUT
);
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_RELEASE, ST_WAIT} state_t;

   localparam int DEPTH  = 1 << RFBW;
   localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int PH_BW  = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   state_t            state, state_nxt;
   logic [PH_BW-1:0]  ph_cnt, ph_nxt;
   logic [30:0]       cmd_q;
   logic [31:0]       data_q;
   logic              stb_q, busy_q, rdy_q, rsp_vld_q;
   logic              accept, push, pop, is_wait, rd_type, tmo_exp;
   logic [31:0]       mem [DEPTH];
   logic [RFBW-1:0]   wr_ptr, rd_ptr;
   logic [RFBW:0]     cnt, cnt_nxt;

   assign is_wait = (iREQ_CMD[30:24] == 7'h7F);
   assign rd_type = (cmd_q[30:24] == 7'd1) || (cmd_q[30:24] == 7'd4);
   assign pop     = rsp_vld_q & iRSP_READY;

   always_comb begin
      state_nxt = state;
      ph_nxt    = ph_cnt;
      accept    = 1'b0;
      push      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (iREQ_VALID && rdy_q) begin
               accept = 1'b1;
               if (is_wait) begin
                  state_nxt = ST_WAIT;
               end else begin
                  state_nxt = ST_SETUP;
                  ph_nxt    = PH_BW'(SETUP_CYC - 1);
               end
            end
         end
         ST_SETUP: begin
            if (ph_cnt == '0) begin
               state_nxt = ST_STROBE;
               ph_nxt    = PH_BW'(HOLD_CYC - 1);
            end else begin
               ph_nxt = ph_cnt - 1'b1;
            end
         end
         ST_STROBE: begin
            if (ph_cnt == '0) state_nxt = ST_RELEASE;
            else              ph_nxt    = ph_cnt - 1'b1;
         end
         ST_RELEASE: begin
            push      = rd_type;
            state_nxt = ST_IDLE;
         end
         ST_WAIT: begin
            if (iDONE || tmo_exp) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_nxt = cnt;
      if (push && !pop)      cnt_nxt = cnt + 1'b1;
      else if (pop && !push) cnt_nxt = cnt - 1'b1;
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_ff @(posedge opclk or negedge inRST) begin
      if (!inRST) begin
         state     <= ST_IDLE;
         ph_cnt    <= '0;
         cmd_q     <= '0;
         data_q    <= '0;
         stb_q     <= 1'b0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b1;
         rsp_vld_q <= 1'b0;
         cnt       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
      end else begin
         state  <= state_nxt;
         ph_cnt <= ph_nxt;
         if (accept && !is_wait) begin
            cmd_q  <= iREQ_CMD;
            data_q <= iREQ_DATA;
         end
         stb_q     <= (state_nxt == ST_STROBE);
         busy_q    <= (state_nxt != ST_IDLE);
         rdy_q     <= (state_nxt == ST_IDLE) && !cnt_nxt[RFBW];
         rsp_vld_q <= (cnt_nxt != '0);
         cnt       <= cnt_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge opclk) begin
      if (push) mem[wr_ptr] <= iRDATA;
   end

`ifdef GPPCU_CMD_TIMEOUT_EN
   logic [TMO_BW-1:0] tmo_cnt;
   logic              tmo_q, tmo_hit;

   // A loaded limit of 0 never reaches 1, so it waits forever.
   assign tmo_exp = (tmo_cnt == TMO_BW'(1));
   assign tmo_hit = (state == ST_WAIT) && !iDONE && tmo_exp;

   always_ff @(posedge opclk or negedge inRST) begin
      if (!inRST) begin
         tmo_cnt <= '0;
         tmo_q   <= 1'b0;
      end else begin
         if (accept)                                tmo_cnt <= iREQ_DATA[TMO_BW-1:0];
         else if (state == ST_WAIT && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
         if (tmo_hit) tmo_q <= 1'b1;
      end
   end

   assign oTIMEOUT = tmo_q;
`else
   assign tmo_exp = 1'b0;

   // TMO_BW must stay legal so both builds accept the same parameter set.
   if (TMO_BW >= 1) begin : g_tmo_tie
      assign oTIMEOUT = 1'b0;
   end
`endif

   assign oREQ_READY = rdy_q;
   assign oCMD       = {stb_q, cmd_q};
   assign oDATA      = data_q;
   assign oRSP_VALID = rsp_vld_q;
   assign oRSP_DATA  = mem[rd_ptr];
   assign oBUSY      = busy_q;

endmodule

// File: tb/tb_gppcu_cmd_issuer.sv
// Directed bench for gppcu_cmd_issuer (RFBW=2); timeout cases build only with GPPCU_CMD_TIMEOUT_EN.
module tb_gppcu_cmd_issuer;
   logic        opclk = 1'b0;
   logic        inRST = 1'b0;
   logic        iREQ_VALID = 1'b0;
   logic        oREQ_READY;
   logic [30:0] iREQ_CMD = '0;
   logic [31:0] iREQ_DATA = '0;
   logic [31:0] oCMD, oDATA;
   logic [31:0] iRDATA = '0;
   logic        iDONE = 1'b0;
   logic        oRSP_VALID;
   logic        iRSP_READY = 1'b0;
   logic [31:0] oRSP_DATA;
   logic        oBUSY, oTIMEOUT;

   int n_chk = 0;
   int n_err = 0;

   gppcu_cmd_issuer #(.SETUP_CYC(1), .HOLD_CYC(1), .RFBW(2), .TMO_BW(16)) dut (
      .opclk(opclk), .inRST(inRST),
      .iREQ_VALID(iREQ_VALID), .oREQ_READY(oREQ_READY),
      .iREQ_CMD(iREQ_CMD), .iREQ_DATA(iREQ_DATA),
      .oCMD(oCMD), .oDATA(oDATA), .iRDATA(iRDATA), .iDONE(iDONE),
      .oRSP_VALID(oRSP_VALID), .iRSP_READY(iRSP_READY), .oRSP_DATA(oRSP_DATA),
      .oBUSY(oBUSY), .oTIMEOUT(oTIMEOUT)
   );

   always #5 opclk = ~opclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge opclk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((oBUSY || !oREQ_READY) && n < 100) begin
         tick();
         n++;
      end
      check("wait_idle", 32'(oBUSY), 32'd0);
   endtask

   // Presents one request for its accepting cycle; returns in the first frame cycle.
   task automatic send(input logic [30:0] c, input logic [31:0] d, input logic [31:0] rd);
      int n = 0;
      while (!oREQ_READY && n < 100) begin
         tick();
         n++;
      end
      check("send_ready", 32'(oREQ_READY), 32'd1);
      iREQ_CMD   = c;
      iREQ_DATA  = d;
      iRDATA     = rd;
      iREQ_VALID = 1'b1;
      tick();
      iREQ_VALID = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] rise_mask;
      logic        prev_stb, busy_all, stb_seen;

      // reset state
      #12;
      check("rst_cmd", oCMD, 32'h0);
      check("rst_data", oDATA, 32'h0);
      check("rst_rspv", 32'(oRSP_VALID), 32'd0);
      check("rst_busy", 32'(oBUSY), 32'd0);
      check("rst_tmo", 32'(oTIMEOUT), 32'd0);
      @(negedge opclk);
      inRST = 1'b1;
      tick();
      check("rst_ready", 32'(oREQ_READY), 32'd1);

      // single WRL frame
      send(31'h0201_0005, 32'h1234, 32'h0);
      check("wrl_setup", oCMD, 32'h0201_0005);
      check("wrl_data", oDATA, 32'h0000_1234);
      check("wrl_busy", 32'(oBUSY), 32'd1);
      tick();
      check("wrl_strobe", oCMD, 32'h8201_0005);
      tick();
      check("wrl_release", oCMD, 32'h0201_0005);
      tick();
      check("wrl_idle_cmd", oCMD, 32'h0201_0005);
      check("wrl_no_rsp", 32'(oRSP_VALID), 32'd0);
      check("wrl_ready", 32'(oREQ_READY), 32'd1);

      // RDL: one response, valid at T+4
      send(31'h0100_0003, 32'h0, 32'hCAFE_0001);
      tick();
      tick();
      check("rdl_t3_rspv", 32'(oRSP_VALID), 32'd0);
      tick();
      check("rdl_t4_rspv", 32'(oRSP_VALID), 32'd1);
      check("rdl_rsp", oRSP_DATA, 32'hCAFE_0001);
      iRSP_READY = 1'b1;
      tick();
      iRSP_READY = 1'b0;
      check("rdl_one_rsp", 32'(oRSP_VALID), 32'd0);

      // back-to-back: strobe rises at T+2, T+6, T+10
      wait_idle();
      iREQ_CMD   = 31'h0201_0007;
      iREQ_DATA  = 32'h55;
      iREQ_VALID = 1'b1;
      rise_mask  = '0;
      prev_stb   = 1'b0;
      for (int c = 1; c < 14; c++) begin
         tick();
         if (c == 9) iREQ_VALID = 1'b0;
         if (oCMD[31] && !prev_stb) rise_mask[c] = 1'b1;
         prev_stb = oCMD[31];
      end
      iREQ_VALID = 1'b0;
      check("b2b_rises", 32'(rise_mask), 32'h0000_0444);

      // full FIFO stalls the fifth request; one pop releases it
      wait_idle();
      send(31'h0100_0001, 32'h0, 32'hA000_0001);
      send(31'h0100_0002, 32'h0, 32'hA000_0002);
      send(31'h0400_0003, 32'h0, 32'hA000_0003);
      send(31'h0100_0004, 32'h0, 32'hA000_0004);
      tick();
      tick();
      tick();
      check("full_ready", 32'(oREQ_READY), 32'd0);
      iREQ_CMD   = 31'h0201_0009;
      iREQ_DATA  = 32'h99;
      iREQ_VALID = 1'b1;
      busy_all   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         busy_all |= oBUSY;
      end
      check("full_stall", 32'(busy_all), 32'd0);
      check("full_head", oRSP_DATA, 32'hA000_0001);
      iRSP_READY = 1'b1;
      tick();
      iRSP_READY = 1'b0;
      check("full_released", 32'(oREQ_READY), 32'd1);
      tick();
      iREQ_VALID = 1'b0;
      check("full_accept", 32'(oBUSY), 32'd1);
      wait_idle();
      iRSP_READY = 1'b1;
      check("order_2", oRSP_DATA, 32'hA000_0002);
      tick();
      check("order_3", oRSP_DATA, 32'hA000_0003);
      tick();
      check("order_4", oRSP_DATA, 32'hA000_0004);
      tick();
      iRSP_READY = 1'b0;
      check("order_empty", 32'(oRSP_VALID), 32'd0);

      // WAIT_DONE: busy for the whole wait, idle one cycle after iDONE
      send(31'h7F00_0000, 32'h0, 32'h0);
      busy_all = 1'b1;
      stb_seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         busy_all &= oBUSY;
         stb_seen |= oCMD[31];
         tick();
      end
      busy_all &= oBUSY;
      iDONE = 1'b1;
      check("wait_busy", 32'(busy_all), 32'd1);
      check("wait_no_strobe", 32'(stb_seen), 32'd0);
      tick();
      iDONE = 1'b0;
      check("wait_done_idle", 32'(oBUSY), 32'd0);
      check("wait_no_tmo", 32'(oTIMEOUT), 32'd0);

`ifdef GPPCU_CMD_TIMEOUT_EN
      // done on the expiry cycle wins
      send(31'h7F00_0000, 32'd3, 32'h0);
      tick();
      tick();
      iDONE = 1'b1;
      tick();
      iDONE = 1'b0;
      check("tmo_tie_idle", 32'(oBUSY), 32'd0);
      check("tmo_tie_flag", 32'(oTIMEOUT), 32'd0);
      // limit 5 with iDONE low
      send(31'h7F00_0000, 32'd5, 32'h0);
      for (int i = 0; i < 4; i++) tick();
      check("tmo_5_busy", 32'(oBUSY), 32'd1);
      check("tmo_5_flag0", 32'(oTIMEOUT), 32'd0);
      tick();
      check("tmo_5_idle", 32'(oBUSY), 32'd0);
      check("tmo_5_flag1", 32'(oTIMEOUT), 32'd1);
`endif

      // reset mid-strobe drops strobe and queued responses
      wait_idle();
      send(31'h0100_0011, 32'h0, 32'hBEEF_0011);
      wait_idle();
      check("pre_rst_rspv", 32'(oRSP_VALID), 32'd1);
      send(31'h0201_0022, 32'h22, 32'h0);
      tick();
      check("pre_rst_stb", 32'(oCMD[31]), 32'd1);
      #2;
      inRST = 1'b0;
      #1;
      check("rst_mid_cmd", oCMD, 32'h0);
      check("rst_mid_rspv", 32'(oRSP_VALID), 32'd0);
      check("rst_mid_busy", 32'(oBUSY), 32'd0);
      tick();
      tick();
      inRST = 1'b1;
      check("rst_rel_ready", 32'(oREQ_READY), 32'd1);
      stb_seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         stb_seen |= oCMD[31];
      end
      check("rst_no_edge", 32'(stb_seen), 32'd0);
      check("rst_tmo_clr", 32'(oTIMEOUT), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
